// File: rtl/clk_ratio_meter_pkg.sv
// Shared definitions for the clock ratio meter: FSM encoding and the
// match-counter width helper.
package clk_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    // Bits needed to count 0..lock_cnt consecutive matching periods.
    function automatic int match_width(input int lock_cnt);
        return $clog2(lock_cnt + 1);
    endfunction

endpackage

// File: rtl/clk_ratio_meter_if.sv
// Measurement bus of the clock ratio meter: signal under test and enable in,
// period/high-time results and status flags out.
interface clk_ratio_meter_if #(
    parameter int CNT_W = 16
);
    logic             sig_in;
    logic             meas_en;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             locked;
    logic             timeout;

    modport master (
        output sig_in, meas_en,
        input  period, high_time, valid, locked, timeout
    );

    modport slave (
        input  sig_in, meas_en,
        output period, high_time, valid, locked, timeout
    );
endinterface

// File: rtl/clk_ratio_meter_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input plus rising-edge detect
// on the synchronized value.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic sync_out_o,
    output logic edge_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = sig_i;
            end else begin : g_rest
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out_o = sync_q[SYNC_STAGES-1];
    assign edge_o     = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a slow clock-derived input in system-clock
// cycles, with lock (stable period) and timeout (input stopped) status.
module clk_ratio_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    clk_ratio_meter_if.slave  bus
);
    localparam int             MW       = match_width(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [MW-1:0]    LOCK_MAX = MW'(LOCK_CNT);
    localparam logic [MW-1:0]    M_ONE    = MW'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [MW-1:0]    match_q, match_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    logic             sync_out;
    logic             edge_det;
    logic [CNT_W:0]   cnt_inc, hcnt_inc;
    logic [CNT_W-1:0] cnt_sat, hcnt_sat;
    logic [MW-1:0]    match_inc;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .sig_i      (bus.sig_in),
        .sync_out_o (sync_out),
        .edge_o     (edge_det)
    );

    // One extra bit of headroom so the counters clamp instead of wrapping.
    assign cnt_inc   = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign hcnt_inc  = {1'b0, hcnt_q} + {{CNT_W{1'b0}}, sync_out};
    assign cnt_sat   = cnt_inc[CNT_W]  ? CNT_MAX : cnt_inc[CNT_W-1:0];
    assign hcnt_sat  = hcnt_inc[CNT_W] ? CNT_MAX : hcnt_inc[CNT_W-1:0];
    assign match_inc = (match_q == LOCK_MAX) ? LOCK_MAX : match_q + M_ONE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        match_d   = match_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        if (!bus.meas_en) begin
            state_d = IDLE;
            cnt_d   = '0;
            hcnt_d  = '0;
            match_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                end
                ARM: begin
                    if (edge_det) begin
                        state_d = MEASURE;
                        cnt_d   = '0;
                        hcnt_d  = CNT_ONE;
                    end else begin
                        cnt_d = cnt_sat;
                        if (cnt_sat == CNT_MAX) begin
                            timeout_d = 1'b1;
                            match_d   = '0;
                        end
                    end
                end
                MEASURE: begin
                    // An edge in the saturating cycle still reports a result.
                    if (edge_det) begin
                        period_d  = cnt_sat;
                        high_d    = hcnt_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = '0;
                        hcnt_d    = CNT_ONE;
                        if (match_q == '0 || cnt_sat != period_q) begin
                            match_d = M_ONE;
                        end else begin
                            match_d = match_inc;
                        end
                    end else begin
                        cnt_d  = cnt_sat;
                        hcnt_d = hcnt_sat;
                        if (cnt_sat == CNT_MAX) begin
                            timeout_d = 1'b1;
                            match_d   = '0;
                            state_d   = ARM;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        locked_d = (match_d == LOCK_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            match_q   <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            match_q   <= match_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.period    = period_q;
    assign bus.high_time = high_q;
    assign bus.valid     = valid_q;
    assign bus.locked    = locked_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Bench for clk_ratio_meter: a 16-bit instance driven from a segment table with
// a result scoreboard, and an 8-bit instance for timeout/saturation sequences.
module tb_clk_ratio_meter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    clk_ratio_meter_if #(.CNT_W(16)) if16 ();
    clk_ratio_meter_if #(.CNT_W(8))  if8 ();

    clk_ratio_meter #(.CNT_W(16), .LOCK_CNT(4), .SYNC_STAGES(2)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    clk_ratio_meter #(.CNT_W(8), .LOCK_CNT(4), .SYNC_STAGES(2)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    typedef struct {
        int   period;
        int   high;
        logic locked;
        int   cyc;
    } exp_t;

    typedef struct {
        int hi;
        int lo;
        int reps;
        int exp_period;
        int exp_high;
    } seg_t;

    exp_t sb[$];
    exp_t mon_e;
    seg_t segs[5];

    int   m_match = 0;
    int   m_prev  = 0;
    bit   have_pend = 1'b0;
    int   pend_p = 0;
    int   pend_h = 0;

    int   v8_cnt = 0;
    int   v8_period = 0;
    int   v8_high = 0;
    logic v8_locked = 1'b0;
    logic v8_timeout = 1'b0;
    int   last_rise8 = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        have_pend = 1'b0;
        m_match   = 0;
    endtask

    // One period on the 16-bit instance: rising edge, hi cycles high, lo low.
    // The rise closes the previous period, so its result is queued now.
    task automatic gen16(input int hi, input int lo, input int ep, input int eh);
        exp_t e;
        if16.sig_in = 1'b1;
        if (have_pend) begin
            if (m_match == 0)          m_match = 1;
            else if (pend_p == m_prev) m_match = (m_match < 4) ? m_match + 1 : 4;
            else                       m_match = 1;
            m_prev   = pend_p;
            e.period = pend_p;
            e.high   = pend_h;
            e.locked = (m_match == 4);
            e.cyc    = cyc;
            sb.push_back(e);
        end
        pend_p    = ep;
        pend_h    = eh;
        have_pend = 1'b1;
        tick(hi);
        if16.sig_in = 1'b0;
        tick(lo);
    endtask

    task automatic gen8(input int hi, input int lo);
        if8.sig_in = 1'b1;
        last_rise8 = cyc;
        tick(hi);
        if8.sig_in = 1'b0;
        tick(lo);
    endtask

    always @(negedge clk) begin
        if (if16.valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid16: got valid=1 at cycle %0d, expected no result pending", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("period16",    32'(if16.period),    32'(mon_e.period));
                check("high_time16", 32'(if16.high_time), 32'(mon_e.high));
                check("locked16",    32'(if16.locked),    32'(mon_e.locked));
                check("timeout16",   32'(if16.timeout),   32'd0);
                check("latency16",   32'(cyc - mon_e.cyc), 32'd3);
                $display("[TB] valid16 cyc=%0d period=%0d high=%0d locked=%0b", cyc,
                         if16.period, if16.high_time, if16.locked);
            end
        end
        if (if8.valid === 1'b1) begin
            v8_cnt++;
            v8_period  = 32'(if8.period);
            v8_high    = 32'(if8.high_time);
            v8_locked  = if8.locked;
            v8_timeout = if8.timeout;
            $display("[TB] valid8 cyc=%0d period=%0d high=%0d locked=%0b", cyc,
                     if8.period, if8.high_time, if8.locked);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int tcyc;

        segs[0] = '{hi: 1, lo: 1, reps: 6, exp_period: 2,  exp_high: 1};
        segs[1] = '{hi: 4, lo: 4, reps: 6, exp_period: 8,  exp_high: 4};
        segs[2] = '{hi: 3, lo: 7, reps: 5, exp_period: 10, exp_high: 3};
        segs[3] = '{hi: 5, lo: 5, reps: 3, exp_period: 10, exp_high: 5};
        segs[4] = '{hi: 6, lo: 6, reps: 5, exp_period: 12, exp_high: 6};

        if16.sig_in = 1'b0; if16.meas_en = 1'b0;
        if8.sig_in  = 1'b0; if8.meas_en  = 1'b0;

        #12;
        check("rst_period16",  32'(if16.period),    32'd0);
        check("rst_high16",    32'(if16.high_time), 32'd0);
        check("rst_valid16",   32'(if16.valid),     32'd0);
        check("rst_locked16",  32'(if16.locked),    32'd0);
        check("rst_timeout16", 32'(if16.timeout),   32'd0);
        check("rst_period8",   32'(if8.period),     32'd0);
        check("rst_timeout8",  32'(if8.timeout),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick(1);

        // Table-driven waveforms on the 16-bit instance.
        if16.meas_en = 1'b1;
        tick(2);
        for (int s = 0; s < 5; s++) begin
            for (int r = 0; r < segs[s].reps; r++) begin
                gen16(segs[s].hi, segs[s].lo, segs[s].exp_period, segs[s].exp_high);
            end
        end
        gen16(2, 2, 4, 2);
        tick(2);
        check("sb_drained_table", 32'(sb.size()), 32'd0);
        check("locked_before_drop", 32'(if16.locked), 32'd1);

        // Drop meas_en mid-period: status clears next cycle, results hold.
        if16.meas_en = 1'b0;
        model_reset();
        tick(1);
        check("drop_valid",  32'(if16.valid),     32'd0);
        check("drop_locked", 32'(if16.locked),    32'd0);
        check("drop_period", 32'(if16.period),    32'd12);
        check("drop_high",   32'(if16.high_time), 32'd6);
        tick(3);
        if16.meas_en = 1'b1;
        tick(1);
        for (int r = 0; r < 3; r++) gen16(4, 4, 8, 4);
        tick(1);
        check("sb_drained_reenable", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-period.
        #3;
        rst = 1'b0;
        #1;
        check("arst_period16",  32'(if16.period),    32'd0);
        check("arst_high16",    32'(if16.high_time), 32'd0);
        check("arst_valid16",   32'(if16.valid),     32'd0);
        check("arst_locked16",  32'(if16.locked),    32'd0);
        check("arst_timeout16", 32'(if16.timeout),   32'd0);
        #2;
        rst = 1'b1;
        model_reset();
        tick(2);
        for (int r = 0; r < 3; r++) gen16(3, 3, 6, 3);
        tick(2);
        check("sb_drained_reset", 32'(sb.size()), 32'd0);
        if16.meas_en = 1'b0;
        model_reset();

        // 8-bit instance: lock, then stop the input and wait for timeout.
        if8.meas_en = 1'b1;
        tick(2);
        for (int r = 0; r < 6; r++) gen8(4, 4);
        check("lock8_count",   32'(v8_cnt),    32'd5);
        check("lock8_period",  32'(v8_period), 32'd8);
        check("lock8_high",    32'(v8_high),   32'd4);
        check("lock8_locked",  32'(v8_locked), 32'd1);

        seen = 1'b0;
        tcyc = 0;
        for (int i = 0; i < 400; i++) begin
            if (if8.timeout === 1'b1) begin
                seen = 1'b1;
                tcyc = cyc;
                break;
            end
            tick(1);
        end
        check("timeout8_seen",   32'(seen),              32'd1);
        check("timeout8_delay",  32'(tcyc - last_rise8), 32'd258);
        check("timeout8_locked", 32'(if8.locked),        32'd0);
        check("timeout8_nvalid", 32'(v8_cnt),            32'd5);

        gen8(4, 4);
        check("rearm8_no_valid",  32'(v8_cnt),      32'd5);
        check("rearm8_timeout",   32'(if8.timeout), 32'd1);
        gen8(4, 4);
        check("recover8_count",   32'(v8_cnt),      32'd6);
        check("recover8_vtime",   32'(v8_timeout),  32'd0);
        check("recover8_period",  32'(v8_period),   32'd8);
        check("recover8_timeout", 32'(if8.timeout), 32'd0);

        // Edge arriving in the very cycle the counter saturates.
        gen8(1, 254);
        gen8(1, 3);
        check("sat8_count",   32'(v8_cnt),      32'd8);
        check("sat8_period",  32'(v8_period),   32'd255);
        check("sat8_high",    32'(v8_high),     32'd1);
        check("sat8_vtime",   32'(v8_timeout),  32'd0);
        check("sat8_timeout", 32'(if8.timeout), 32'd0);

        tick(5);
        check("sb_drained_end", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
